updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 16: count sequence length, legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel-load strobe.
REQ-008 load_val  input  WIDTH  value applied on load.
REQ-009 count  output  WIDTH  registered current count.
REQ-010 tc  output  1  combinational terminal-count flag.
REQ-011 wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-012 count SHALL always lie in 0..MODULUS-1.
REQ-013 Priority per rising edge SHALL be load, then en, then hold.
REQ-014 When load=1, count SHALL take load_val on the next edge, regardless of en and up_dn.
REQ-015 If load_val >= MODULUS during a load, count SHALL take MODULUS-1 instead.
REQ-016 When load=0, en=1 and up_dn=1: count SHALL increment by 1, with MODULUS-1 going to 0.
REQ-017 When load=0, en=1 and up_dn=0: count SHALL decrement by 1, with 0 going to MODULUS-1.
REQ-018 When load=0 and en=0, count SHALL hold its value.
REQ-019 tc SHALL be 1 if and only if en=1 and load=0 and count is at the terminal value for the current direction (MODULUS-1 up, 0 down).
REQ-020 wrap SHALL be 1 for exactly one cycle, in the cycle after an edge on which count wrapped; otherwise it SHALL be 0.
REQ-021 A load SHALL never generate wrap, even when the loaded value equals a terminal value.
REQ-022 Changing up_dn on any cycle SHALL take effect on the next edge, with no lost or extra step.
REQ-023 When MODULUS = 2**WIDTH, wrap-around SHALL be exact binary overflow/underflow with no illegal intermediate value.
REQ-024 The block SHALL be fully synchronous apart from reset, with no ripple or derived clocks.

Reset
REQ-025 reset=0 SHALL asynchronously force count=0 and wrap=0.
REQ-026 While reset=0, tc SHALL be 0, because count is forced and the tc qualifiers are ignored.
REQ-027 Reset asserted mid-count or mid-load SHALL abort the operation, and no wrap SHALL appear after release.
REQ-028 The first edge after reset release SHALL evaluate load and en normally.

Configuration
REQ-029 Macro COUNTER_SATURATE_EN SHALL select end-of-range behaviour.
REQ-030 With COUNTER_SATURATE_EN defined: at a terminal value with en=1, count SHALL hold instead of wrapping, wrap SHALL stay 0, and tc SHALL still assert per REQ-019.
REQ-031 Without COUNTER_SATURATE_EN: modulo wrap-around per REQ-016 and REQ-017.

Verification
REQ-032 Defaults, reset 0 for 10 ns then 1, en=1, up_dn=1, 20 edges -> count 0,1,..,15,0,1,2,3; tc=1 only at count=15; wrap=1 for one cycle when count=0 after 15.
REQ-033 MODULUS=10, up_dn=0 from 0 -> count 9,8,..,0,9; tc=1 at count=0; wrap pulse after 0->9.
REQ-034 load=1, load_val=7 with en=1 -> count=7 next edge, no wrap; MODULUS=10 with load_val=12 -> count=9.
REQ-035 Counting up, count=5: flip up_dn to 0 -> 6 then 5,4; then en=0 for 3 cycles -> count holds at 4.
REQ-036 reset pulsed low between edges at count=9 -> count=0 immediately and wrap=0; resumes 1,2 after release.
REQ-037 COUNTER_SATURATE_EN defined, defaults, 20 edges up -> count sticks at 15, tc=1, wrap never asserts.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle between a counter client and updown_mod_counter.
// Latency: none; wires only.
// Backpressure: none; the client drives controls every cycle.
interface updown_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;

   // Client side: drives controls, observes the counter state.
   modport master (
      output en, up_dn, load, load_val,
      input  count, tc, wrap
   );

   // Counter side.
   modport slave (
      input  en, up_dn, load, load_val,
      output count, tc, wrap
   );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with clamped parallel load, tc and wrap flags.
// Latency: count and wrap registered (1 cycle); tc combinational from current inputs.
// Backpressure: none; en=0 holds. Macro COUNTER_SATURATE_EN: stick at range ends instead of wrapping.
module updown_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input logic                 clk,
   input logic                 reset,
   updown_mod_counter_if.slave bus
);
   // Widened modulus so MODULUS = 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_q;
   logic             wrap_nxt;
   logic             at_term;

   // Terminal value depends on direction: top of range going up, zero going down.
   always_comb begin
      at_term = bus.up_dn ? (count_q == TOP) : (count_q == '0);
   end

   // Next state: load beats enable beats hold; loads never flag a wrap.
   always_comb begin
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      if (bus.load) begin
         if ({1'b0, bus.load_val} >= MOD_EXT) begin
            count_nxt = TOP;
         end else begin
            count_nxt = bus.load_val;
         end
      end else if (bus.en) begin
         if (at_term) begin
`ifdef COUNTER_SATURATE_EN
            count_nxt = count_q;
`else
            count_nxt = bus.up_dn ? '0 : TOP;
            wrap_nxt  = 1'b1;
`endif
         end else begin
            count_nxt = bus.up_dn ? (count_q + ONE) : (count_q - ONE);
         end
      end
   end

   // State register; reset clears count and any pending wrap pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wrap_q  <= wrap_nxt;
      end
   end

   // tc is masked during reset so a forced zero count cannot look terminal.
   assign bus.tc    = reset & bus.en & ~bus.load & at_term;
   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: modulus-16 and modulus-10 instances.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: n/a; inputs driven directly from tasks.
module tb_updown_mod_counter;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   updown_mod_counter_if #(.WIDTH(4)) b16 ();
   updown_mod_counter_if #(.WIDTH(4)) b10 ();

   updown_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk   (clk),
      .reset (reset),
      .bus   (b10)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      b16.en = 1'b1; b16.up_dn = 1'b0; b16.load = 1'b0; b16.load_val = '0;
      b10.en = 1'b1; b10.up_dn = 1'b0; b10.load = 1'b0; b10.load_val = '0;
      reset = 1'b0;
      #2;
      tests_run++;
      if (b16.count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_count: got %0d expected 0", b16.count);
      end
      tests_run++;
      if (b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_wrap: got %0b expected 0", b16.wrap);
      end
      tests_run++;
      if (b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_tc16: got %0b expected 0", b16.tc);
      end
      tests_run++;
      if (b10.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_tc10: got %0b expected 0", b10.tc);
      end
      #8;
      reset = 1'b1;
      b16.up_dn = 1'b1;
      b10.en = 1'b0;
      #1;
   endtask

   task automatic test_count_up();
      logic [3:0] exp_cnt;
      logic       exp_wrap;
      tests_run++;
      if (b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL up_tc_start: got %0b expected 0", b16.tc);
      end
      for (int i = 1; i <= 20; i++) begin
         tick();
`ifdef COUNTER_SATURATE_EN
         exp_cnt  = (i >= 15) ? 4'd15 : 4'(i);
         exp_wrap = 1'b0;
`else
         exp_cnt  = 4'(i % 16);
         exp_wrap = (i == 16);
`endif
         tests_run++;
         if (b16.count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL up_count[%0d]: got %0d expected %0d", i, b16.count, exp_cnt);
         end
         tests_run++;
         if (b16.wrap !== exp_wrap) begin
            tests_failed++;
            $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, b16.wrap, exp_wrap);
         end
         tests_run++;
         if (b16.tc !== (exp_cnt == 4'd15)) begin
            tests_failed++;
            $display("FAIL up_tc[%0d]: got %0b expected %0b", i, b16.tc, exp_cnt == 4'd15);
         end
      end
      b16.en = 1'b0;
   endtask

   task automatic test_count_down();
      logic [3:0] exp_cnt;
      logic       exp_wrap;
      b10.up_dn = 1'b0;
      b10.en    = 1'b1;
      #1;
      tests_run++;
      if (b10.tc !== 1'b1) begin
         tests_failed++;
         $display("FAIL dn_tc_start: got %0b expected 1", b10.tc);
      end
      for (int i = 1; i <= 11; i++) begin
         tick();
`ifdef COUNTER_SATURATE_EN
         exp_cnt  = 4'd0;
         exp_wrap = 1'b0;
`else
         exp_cnt  = 4'((10 - (i % 10)) % 10);
         exp_wrap = ((i % 10) == 1);
`endif
         tests_run++;
         if (b10.count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL dn_count[%0d]: got %0d expected %0d", i, b10.count, exp_cnt);
         end
         tests_run++;
         if (b10.wrap !== exp_wrap) begin
            tests_failed++;
            $display("FAIL dn_wrap[%0d]: got %0b expected %0b", i, b10.wrap, exp_wrap);
         end
         tests_run++;
         if (b10.tc !== (exp_cnt == 4'd0)) begin
            tests_failed++;
            $display("FAIL dn_tc[%0d]: got %0b expected %0b", i, b10.tc, exp_cnt == 4'd0);
         end
      end
      b10.en = 1'b0;
   endtask

   task automatic test_load();
      // Load ignores en/up_dn and never raises wrap, even onto a terminal value.
      b16.en = 1'b1; b16.up_dn = 1'b1; b16.load = 1'b1; b16.load_val = 4'd7;
      tick();
      tests_run++;
      if (b16.count !== 4'd7 || b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL load7: got count=%0d wrap=%0b expected count=7 wrap=0", b16.count, b16.wrap);
      end
      b16.load_val = 4'd15;
      tick();
      tests_run++;
      if (b16.count !== 4'd15 || b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL load15: got count=%0d wrap=%0b expected count=15 wrap=0", b16.count, b16.wrap);
      end
      tests_run++;
      if (b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_tc_masked: got %0b expected 0", b16.tc);
      end
      b16.load = 1'b0;
      #1;
      tests_run++;
      if (b16.tc !== 1'b1) begin
         tests_failed++;
         $display("FAIL tc_up_at15: got %0b expected 1", b16.tc);
      end
      b16.up_dn = 1'b0;
      #1;
      tests_run++;
      if (b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL tc_dn_at15: got %0b expected 0", b16.tc);
      end
      b16.up_dn = 1'b1; b16.en = 1'b0;
      #1;
      tests_run++;
      if (b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL tc_en0_at15: got %0b expected 0", b16.tc);
      end
      // At 15 counting up, a load of 0 must win over the wrap.
      b16.en = 1'b1; b16.load = 1'b1; b16.load_val = 4'd0;
      tick();
      tests_run++;
      if (b16.count !== 4'd0 || b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_over_wrap: got count=%0d wrap=%0b expected count=0 wrap=0", b16.count, b16.wrap);
      end
      b16.load = 1'b0; b16.en = 1'b0;
      // Out-of-range loads clamp to MODULUS-1 on the modulus-10 instance.
      b10.en = 1'b1; b10.up_dn = 1'b1; b10.load = 1'b1; b10.load_val = 4'd12;
      tick();
      tests_run++;
      if (b10.count !== 4'd9 || b10.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL load12_m10: got count=%0d wrap=%0b expected count=9 wrap=0", b10.count, b10.wrap);
      end
      b10.load_val = 4'd3;
      tick();
      tests_run++;
      if (b10.count !== 4'd3) begin
         tests_failed++;
         $display("FAIL load3_m10: got %0d expected 3", b10.count);
      end
      b10.load_val = 4'd10;
      tick();
      tests_run++;
      if (b10.count !== 4'd9) begin
         tests_failed++;
         $display("FAIL load10_m10: got %0d expected 9", b10.count);
      end
      b10.load = 1'b0; b10.en = 1'b0;
   endtask

   task automatic test_direction();
      b16.en = 1'b1; b16.up_dn = 1'b1; b16.load = 1'b1; b16.load_val = 4'd4;
      tick();
      b16.load = 1'b0;
      tick();
      tests_run++;
      if (b16.count !== 4'd5) begin
         tests_failed++;
         $display("FAIL dir_up5: got %0d expected 5", b16.count);
      end
      tick();
      tests_run++;
      if (b16.count !== 4'd6) begin
         tests_failed++;
         $display("FAIL dir_up6: got %0d expected 6", b16.count);
      end
      b16.up_dn = 1'b0;
      tick();
      tests_run++;
      if (b16.count !== 4'd5) begin
         tests_failed++;
         $display("FAIL dir_dn5: got %0d expected 5", b16.count);
      end
      tick();
      tests_run++;
      if (b16.count !== 4'd4) begin
         tests_failed++;
         $display("FAIL dir_dn4: got %0d expected 4", b16.count);
      end
      b16.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (b16.count !== 4'd4 || b16.tc !== 1'b0 || b16.wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold[%0d]: got count=%0d tc=%0b wrap=%0b expected 4/0/0", i, b16.count, b16.tc, b16.wrap);
         end
      end
   endtask

   task automatic test_reset_mid();
      b16.en = 1'b1; b16.up_dn = 1'b1; b16.load = 1'b1; b16.load_val = 4'd8;
      tick();
      b16.load = 1'b0;
      tick();
      tests_run++;
      if (b16.count !== 4'd9) begin
         tests_failed++;
         $display("FAIL rst_pre9: got %0d expected 9", b16.count);
      end
      #1 reset = 1'b0;
      #1;
      tests_run++;
      if (b16.count !== 4'd0 || b16.wrap !== 1'b0 || b16.tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_async: got count=%0d wrap=%0b tc=%0b expected 0/0/0", b16.count, b16.wrap, b16.tc);
      end
      #1 reset = 1'b1;
      tick();
      tests_run++;
      if (b16.count !== 4'd1 || b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_resume1: got count=%0d wrap=%0b expected 1/0", b16.count, b16.wrap);
      end
      tick();
      tests_run++;
      if (b16.count !== 4'd2) begin
         tests_failed++;
         $display("FAIL rst_resume2: got %0d expected 2", b16.count);
      end
      // Reset while sitting at the wrap point: no wrap after release.
      b16.load = 1'b1; b16.load_val = 4'd15;
      tick();
      b16.load = 1'b0;
      #1 reset = 1'b0;
      #2 reset = 1'b1;
      tick();
      tests_run++;
      if (b16.count !== 4'd1 || b16.wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_at15: got count=%0d wrap=%0b expected 1/0", b16.count, b16.wrap);
      end
      b16.en = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_direction();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
